// File: rtl/alu8_cmd_port.sv
// Valid/ready command front-end for the 8-bit ALU: registers the ALU inputs,
// captures the combinational result one cycle later and queues tagged responses.
module alu8_cmd_port #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [2:0]                    req_opcode,
  input  logic [7:0]                    req_a,
  input  logic [7:0]                    req_b,
  input  logic [TAG_W-1:0]              req_tag,
  output logic [2:0]                    alu_opcode,
  output logic [7:0]                    alu_a,
  output logic [7:0]                    alu_b,
  input  logic [15:0]                   alu_result,
  input  logic                          alu_flag_c,
  input  logic                          alu_flag_z,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [15:0]                   rsp_result,
  output logic                          rsp_flag_c,
  output logic                          rsp_flag_z,
  output logic                          rsp_err,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 16 + 3 + TAG_W;

  logic [2:0]       r_alu_opcode;
  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic [TAG_W-1:0] r_tag;
  logic             r_illegal;
  logic             r_inflight;

  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic [AW:0]      w_occ;
  logic [AW+1:0]    w_level;
  logic [EW-1:0]    w_push_entry;
  logic [EW-1:0]    w_head;

  assign w_occ     = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // The in-flight capture is counted so a push always finds a free slot.
  assign w_level   = {1'b0, w_occ} + (AW+2)'(r_inflight);
  assign req_ready = rst_n && (w_level < (AW+2)'(FIFO_DEPTH));
  assign w_accept  = req_valid && req_ready;
  assign w_push    = r_inflight && !w_full;
  assign w_pop     = rsp_valid && rsp_ready;

  assign w_push_entry = r_illegal ? {16'h0000, 1'b0, 1'b0, 1'b1, r_tag}
                                  : {alu_result, alu_flag_c, alu_flag_z, 1'b0, r_tag};

  // Stage 0: issue to the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_opcode <= 3'b000;
      r_alu_a      <= 8'h00;
      r_alu_b      <= 8'h00;
      r_tag        <= '0;
      r_illegal    <= 1'b0;
      r_inflight   <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_alu_opcode <= req_opcode;
        r_alu_a      <= req_a;
        r_alu_b      <= req_b;
        r_tag        <= req_tag;
        r_illegal    <= (req_opcode > 3'b100);
      end
    end
  end

  // Stage 1: capture ALU output into the response FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= w_push_entry;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign rsp_valid  = !w_empty;
  assign rsp_result = w_head[EW-1 -: 16];
  assign rsp_flag_c = w_head[TAG_W+2];
  assign rsp_flag_z = w_head[TAG_W+1];
  assign rsp_err    = w_head[TAG_W];
  assign rsp_tag    = w_head[TAG_W-1:0];
  assign occupancy  = w_occ;

  assign alu_opcode = r_alu_opcode;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;

endmodule

// File: tb/tb_alu8_cmd_port.sv
// Bench for alu8_cmd_port: behavioural ALU, scoreboard of expected responses,
// directed latency/ordering/back-pressure/reset scenarios and a random stall run.
module tb_alu8_cmd_port;

  localparam int DEPTH = 4;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        err;
    logic [3:0]  tag;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_opcode = 3'b000;
  logic [7:0]  req_a = 8'h00;
  logic [7:0]  req_b = 8'h00;
  logic [3:0]  req_tag = 4'h0;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [15:0] alu_result;
  logic        alu_flag_c;
  logic        alu_flag_z;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_flag_c;
  logic        rsp_flag_z;
  logic        rsp_err;
  logic [3:0]  rsp_tag;
  logic [2:0]  occupancy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_acc = 0;
  int n_pop = 0;

  rsp_t sb[$];
  rsp_t q_log[$];
  int   log_cyc[$];
  int   m_occ  = 0;
  int   m_infl = 0;

  alu8_cmd_port #(.FIFO_DEPTH(DEPTH), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flag_c(alu_flag_c), .alu_flag_z(alu_flag_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flag_c(rsp_flag_c), .rsp_flag_z(rsp_flag_z), .rsp_err(rsp_err),
    .rsp_tag(rsp_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU; undefined opcodes produce junk that must never be returned.
  function automatic logic [17:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic [8:0]  s;
    logic        c;
    r = 16'h0000;
    c = 1'b0;
    s = 9'h000;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = {7'h00, s}; c = s[8]; end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r = {8'h00, s[7:0]}; c = s[8]; end
      3'd2: begin r = 16'(a) * 16'(b); c = |r[15:8]; end
      3'd3: r = {8'h00, a & b};
      3'd4: r = {8'h00, a | b};
      default: begin r = 16'hDEAD; c = 1'b1; end
    endcase
    if (op > 3'd4) return {r, c, 1'b1};
    return {r, c, (r == 16'h0000)};
  endfunction

  always_comb begin
    logic [17:0] v;
    v = alu_f(alu_opcode, alu_a, alu_b);
    alu_result = v[17:2];
    alu_flag_c = v[1];
    alu_flag_z = v[0];
  end

  // Scoreboard and occupancy model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_occ  = 0;
      m_infl = 0;
    end else begin
      logic acc;
      logic pop;
      total++;
      if (occupancy !== 3'(m_occ)) begin
        bad++;
        $display("FAIL occupancy cyc=%0d got=%0d want=%0d", cyc, occupancy, m_occ);
      end
      total++;
      if (rsp_valid !== (m_occ != 0)) begin
        bad++;
        $display("FAIL rsp_valid cyc=%0d got=%b want=%b", cyc, rsp_valid, (m_occ != 0));
      end
      total++;
      if (req_ready !== ((m_occ + m_infl) < DEPTH)) begin
        bad++;
        $display("FAIL req_ready cyc=%0d got=%b want=%b", cyc, req_ready, ((m_occ + m_infl) < DEPTH));
      end
      if (rsp_valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL spurious_rsp cyc=%0d got tag=%0d want no response", cyc, rsp_tag);
        end else if (rsp_result !== sb[0].res || rsp_flag_c !== sb[0].c || rsp_flag_z !== sb[0].z ||
                     rsp_err !== sb[0].err || rsp_tag !== sb[0].tag) begin
          bad++;
          $display("FAIL head cyc=%0d got res=%h c=%b z=%b err=%b tag=%0d want res=%h c=%b z=%b err=%b tag=%0d",
                   cyc, rsp_result, rsp_flag_c, rsp_flag_z, rsp_err, rsp_tag,
                   sb[0].res, sb[0].c, sb[0].z, sb[0].err, sb[0].tag);
        end
      end
      pop = rsp_valid && rsp_ready;
      acc = req_valid && req_ready;
      if (pop) begin
        rsp_t h;
        h.res = rsp_result; h.c = rsp_flag_c; h.z = rsp_flag_z; h.err = rsp_err; h.tag = rsp_tag;
        q_log.push_back(h);
        log_cyc.push_back(cyc);
        n_pop++;
        if (sb.size() > 0) void'(sb.pop_front());
      end
      if (acc) begin
        rsp_t e;
        logic [17:0] v;
        v = alu_f(req_opcode, req_a, req_b);
        if (req_opcode > 3'd4) begin
          e.res = 16'h0000; e.c = 1'b0; e.z = 1'b0; e.err = 1'b1;
        end else begin
          e.res = v[17:2]; e.c = v[1]; e.z = v[0]; e.err = 1'b0;
        end
        e.tag = req_tag;
        sb.push_back(e);
        n_acc++;
      end
      m_occ  = m_occ + m_infl - (pop ? 1 : 0);
      m_infl = acc ? 1 : 0;
    end
  end

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
    int   n;
    logic ok;
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_tag = tag;
    n = 0;
    do begin
      @(negedge clk); ok = req_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 60);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout tag=%0d got no accept want accept within 60 cycles", tag);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || occupancy !== 3'd0 ||
        alu_opcode !== 3'd0 || alu_a !== 8'h00 || alu_b !== 8'h00 ||
        rsp_result !== 16'h0000 || rsp_tag !== 4'h0 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got rdy=%b vld=%b occ=%0d op=%0d a=%h b=%h res=%h tag=%0d want all 0",
               req_ready, rsp_valid, occupancy, alu_opcode, alu_a, alu_b, rsp_result, rsp_tag);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset got=%b want=1", req_ready);
    end
  endtask

  task automatic test_add();
    rsp_ready = 1'b0;
    send(3'd0, 8'hAA, 8'hCC, 4'd1);
    req_valid = 1'b0;
    total++;
    if (alu_opcode !== 3'd0 || alu_a !== 8'hAA || alu_b !== 8'hCC || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL add_issue got op=%0d a=%h b=%h vld=%b want op=0 a=aa b=cc vld=0",
               alu_opcode, alu_a, alu_b, rsp_valid);
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_result !== 16'h0176 || rsp_flag_c !== 1'b1 ||
        rsp_flag_z !== 1'b0 || rsp_err !== 1'b0 || rsp_tag !== 4'd1) begin
      bad++;
      $display("FAIL add_rsp got vld=%b res=%h c=%b z=%b err=%b tag=%0d want vld=1 res=0176 c=1 z=0 err=0 tag=1",
               rsp_valid, rsp_result, rsp_flag_c, rsp_flag_z, rsp_err, rsp_tag);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL add_pop got vld=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_res [4];
    exp_res[0] = 16'h0022; exp_res[1] = 16'h10EF; exp_res[2] = 16'h0088; exp_res[3] = 16'h00EE;
    q_log.delete(); log_cyc.delete();
    rsp_ready = 1'b1;
    send(3'd1, 8'hCC, 8'hAA, 4'd2);
    send(3'd2, 8'h55, 8'h33, 4'd3);
    send(3'd3, 8'hCC, 8'hAA, 4'd4);
    send(3'd4, 8'hCC, 8'hAA, 4'd5);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (q_log.size() != 4) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=4", q_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (q_log[i].res !== exp_res[i] || q_log[i].tag !== 4'(i + 2) || q_log[i].err !== 1'b0 ||
            log_cyc[i] != log_cyc[0] + i) begin
          bad++;
          $display("FAIL b2b_rsp%0d got res=%h tag=%0d err=%b dcyc=%0d want res=%h tag=%0d err=0 dcyc=%0d",
                   i, q_log[i].res, q_log[i].tag, q_log[i].err, log_cyc[i] - log_cyc[0], exp_res[i], i + 2, i);
        end
      end
    end
  endtask

  task automatic test_illegal();
    q_log.delete(); log_cyc.delete();
    rsp_ready = 1'b1;
    send(3'b110, 8'h12, 8'h34, 4'd7);
    send(3'd0, 8'h01, 8'h02, 4'd8);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (q_log.size() != 2) begin
      bad++;
      $display("FAIL illegal_count got=%0d want=2", q_log.size());
    end else begin
      total++;
      if (q_log[0].res !== 16'h0000 || q_log[0].c !== 1'b0 || q_log[0].z !== 1'b0 ||
          q_log[0].err !== 1'b1 || q_log[0].tag !== 4'd7) begin
        bad++;
        $display("FAIL illegal_rsp got res=%h c=%b z=%b err=%b tag=%0d want res=0000 c=0 z=0 err=1 tag=7",
                 q_log[0].res, q_log[0].c, q_log[0].z, q_log[0].err, q_log[0].tag);
      end
      total++;
      if (q_log[1].res !== 16'h0003 || q_log[1].err !== 1'b0 || q_log[1].z !== 1'b0 || q_log[1].tag !== 4'd8) begin
        bad++;
        $display("FAIL after_illegal got res=%h err=%b z=%b tag=%0d want res=0003 err=0 z=0 tag=8",
                 q_log[1].res, q_log[1].err, q_log[1].z, q_log[1].tag);
      end
    end
  endtask

  task automatic test_full();
    int   acc;
    logic ok;
    logic [3:0] tag;
    q_log.delete(); log_cyc.delete();
    rsp_ready = 1'b0;
    acc = 0;
    tag = 4'd10;
    req_valid = 1'b1; req_opcode = 3'd0; req_a = 8'h10; req_b = 8'(tag); req_tag = tag;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); ok = req_ready;
      @(posedge clk); #1;
      if (ok) begin
        acc++;
        tag = tag + 4'd1;
        req_b = 8'(tag); req_tag = tag;
      end
    end
    total++;
    if (acc != DEPTH || req_ready !== 1'b0 || occupancy !== 3'd4) begin
      bad++;
      $display("FAIL full_accepts got acc=%0d rdy=%b occ=%0d want acc=4 rdy=0 occ=4", acc, req_ready, occupancy);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1 || occupancy !== 3'd3) begin
      bad++;
      $display("FAIL full_reopen got rdy=%b occ=%0d want rdy=1 occ=3", req_ready, occupancy);
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (q_log.size() != 4) begin
      bad++;
      $display("FAIL full_drain got=%0d want=4", q_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (q_log[i].tag !== 4'(10 + i) || q_log[i].res !== 16'(8'h10 + 8'(10 + i))) begin
          bad++;
          $display("FAIL full_order%0d got tag=%0d res=%h want tag=%0d res=%h",
                   i, q_log[i].tag, q_log[i].res, 10 + i, 16'(8'h10 + 8'(10 + i)));
        end
      end
    end
  endtask

  task automatic test_stall_random();
    int  acc0;
    int  pop0;
    int  n;
    logic done;
    acc0 = n_acc;
    pop0 = n_pop;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 4'(i));
          if ($urandom_range(0, 3) == 0) begin
            req_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
        req_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom);
        end
      end
    join
    rsp_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (sb.size() != 0 || n_acc - acc0 != 200 || n_pop - pop0 != 200) begin
      bad++;
      $display("FAIL stall_totals got left=%0d acc=%0d pop=%0d want left=0 acc=200 pop=200",
               sb.size(), n_acc - acc0, n_pop - pop0);
    end
  endtask

  task automatic test_reset_midstream();
    rsp_ready = 1'b0;
    send(3'd0, 8'h01, 8'h01, 4'd1);
    send(3'd0, 8'h02, 8'h02, 4'd2);
    send(3'd0, 8'h03, 8'h03, 4'd3);
    send(3'd0, 8'h04, 8'h04, 4'd4);
    req_valid = 1'b0;
    total++;
    if (occupancy !== 3'd3) begin
      bad++;
      $display("FAIL pre_reset_occ got=%0d want=3", occupancy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || occupancy !== 3'd0 || alu_opcode !== 3'd0 ||
        alu_a !== 8'h00 || alu_b !== 8'h00 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL midstream_reset got vld=%b occ=%0d op=%0d a=%h b=%h rdy=%b want all 0",
               rsp_valid, occupancy, alu_opcode, alu_a, alu_b, req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(3'd0, 8'h10, 8'h20, 4'd9);
    req_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_early got vld=%b want 0", rsp_valid);
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 4'd9 || rsp_result !== 16'h0030 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_rsp got vld=%b tag=%0d res=%h err=%b want vld=1 tag=9 res=0030 err=0",
               rsp_valid, rsp_tag, rsp_result, rsp_err);
    end
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_drain got left=%0d vld=%b want left=0 vld=0", sb.size(), rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_illegal();
    test_full();
    test_stall_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
